pc_sequencer: RTL and testbench

Parametrised program counter for the microprocessor control path, successor to the fixed 4-bit counter. Adds configurable address width, absolute jump, signed relative branch, and a hardware return-address stack for CALL/RET. Sits between the instruction decoder (supplies `cmd` and `target`) and instruction memory (consumes `count`).

---
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Parametrised program counter with INC/JUMP/BRANCH and an optional CALL/RET
// return-address stack, enabled by defining PC_STACK_EN.
module pc_sequencer #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned RESET_ADDR  = 0,
   localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pc_enable,
   input  logic [2:0]         cmd,
   input  logic [ADDR_W-1:0]  target,
   output logic [ADDR_W-1:0]  count,
   output logic [DEPTH_W-1:0] depth,
   output logic               stack_empty,
   output logic               stack_full,
   output logic               stack_err
);

   localparam logic [2:0] CMD_INC    = 3'b000;
   localparam logic [2:0] CMD_JUMP   = 3'b001;
   localparam logic [2:0] CMD_BRANCH = 3'b010;
   localparam logic [2:0] CMD_CALL   = 3'b011;
   localparam logic [2:0] CMD_RET    = 3'b100;

   logic [ADDR_W-1:0] count_reg;
   logic [ADDR_W-1:0] count_next;
   logic [ADDR_W-1:0] count_inc;

   assign count_inc = count_reg + ADDR_W'(1);
   assign count     = count_reg;

`ifdef PC_STACK_EN
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [DEPTH_W-1:0] depth_reg;
   logic [DEPTH_W-1:0] depth_next;
   logic               err_reg;
   logic               err_next;
   logic               push;
   logic               full;
   logic               empty;
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_idx;
   logic [ADDR_W-1:0]  top;
   logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

   assign full   = (depth_reg == DEPTH_W'(STACK_DEPTH));
   assign empty  = (depth_reg == '0);
   assign wr_idx = IDX_W'(depth_reg);
   // Top-of-stack read is asynchronous so a RET lands in a single cycle.
   assign rd_idx = IDX_W'(depth_reg - DEPTH_W'(1));
   assign top    = stack_mem[rd_idx];

   always_comb begin
      count_next = count_inc;
      depth_next = depth_reg;
      err_next   = err_reg;
      push       = 1'b0;
      case (cmd)
         CMD_JUMP:   count_next = target;
         CMD_BRANCH: count_next = count_reg + target;
         CMD_CALL: begin
            if (!full) begin
               push       = 1'b1;
               count_next = target;
               depth_next = depth_reg + DEPTH_W'(1);
            end else begin
               err_next = 1'b1;
            end
         end
         CMD_RET: begin
            if (!empty) begin
               count_next = top;
               depth_next = depth_reg - DEPTH_W'(1);
            end else begin
               err_next = 1'b1;
            end
         end
         default:    count_next = count_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst && pc_enable && push) begin
         stack_mem[wr_idx] <= count_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= ADDR_W'(RESET_ADDR);
         depth_reg <= '0;
         err_reg   <= 1'b0;
      end else if (pc_enable) begin
         count_reg <= count_next;
         depth_reg <= depth_next;
         err_reg   <= err_next;
      end
   end

   assign depth       = depth_reg;
   assign stack_empty = empty;
   assign stack_full  = full;
   assign stack_err   = err_reg;
`else
   // Without the stack, CALL degenerates to JUMP and RET to INC.
   always_comb begin
      count_next = count_inc;
      case (cmd)
         CMD_JUMP:   count_next = target;
         CMD_BRANCH: count_next = count_reg + target;
         CMD_CALL:   count_next = target;
         CMD_RET:    count_next = count_inc;
         CMD_INC:    count_next = count_inc;
         default:    count_next = count_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= ADDR_W'(RESET_ADDR);
      end else if (pc_enable) begin
         count_reg <= count_next;
      end
   end

   assign depth       = '0;
   assign stack_empty = 1'b1;
   assign stack_full  = 1'b0;
   assign stack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised + directed bench for pc_sequencer against a queue-based reference
// model; the model follows PC_STACK_EN the same way the design does.
module tb_pc_sequencer;

   localparam int AW = 8;
   localparam int SD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pc_enable = 1'b0;
   logic [2:0]    cmd = 3'b000;
   logic [AW-1:0] target = '0;
   logic [AW-1:0] count;
   logic [2:0]    depth;
   logic          stack_empty;
   logic          stack_full;
   logic          stack_err;
   logic [AW-1:0] count_r;
   logic [2:0]    depth_r;
   logic          empty_r;
   logic          full_r;
   logic          err_r;

   pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_ADDR(0)) dut (
      .clk(clk), .rst(rst), .pc_enable(pc_enable), .cmd(cmd), .target(target),
      .count(count), .depth(depth), .stack_empty(stack_empty),
      .stack_full(stack_full), .stack_err(stack_err)
   );

   pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_ADDR(8'h20)) dut_r (
      .clk(clk), .rst(rst), .pc_enable(pc_enable), .cmd(cmd), .target(target),
      .count(count_r), .depth(depth_r), .stack_empty(empty_r),
      .stack_full(full_r), .stack_err(err_r)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state
   int m_count = 0;
   int m_stack[$];
   bit m_err = 0;

`ifdef PC_STACK_EN
   localparam bit STACK_ON = 1'b1;
`else
   localparam bit STACK_ON = 1'b0;
`endif

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model(input bit r, input bit en, input int c, input int t);
      int off;
      if (r) begin
         m_count = 0;
         m_stack.delete();
         m_err = 0;
      end else if (en) begin
         case (c)
            1: m_count = t;
            2: begin
               off = (t >= 128) ? t - 256 : t;
               m_count = (m_count + off + 256) % 256;
            end
            3: begin
               if (!STACK_ON) m_count = t;
               else if (m_stack.size() < SD) begin
                  m_stack.push_back((m_count + 1) % 256);
                  m_count = t;
               end else begin
                  m_count = (m_count + 1) % 256;
                  m_err = 1;
               end
            end
            4: begin
               if (STACK_ON && m_stack.size() > 0) m_count = m_stack.pop_back();
               else begin
                  m_count = (m_count + 1) % 256;
                  if (STACK_ON) m_err = 1;
               end
            end
            default: m_count = (m_count + 1) % 256;
         endcase
      end
   endtask

   task automatic step(input bit r, input bit en, input int c, input int t);
      @(negedge clk);
      rst = r; pc_enable = en; cmd = 3'(c); target = 8'(t);
      @(posedge clk);
      #1;
      model(r, en, c, t);
      $display("rst=%0d en=%0d cmd=%0d tgt=%02h -> count=%02h depth=%0d err=%0d",
               r, en, c, t, count, depth, stack_err);
      check("count", int'(count), m_count);
      check("depth", int'(depth), m_stack.size());
      check("empty", int'(stack_empty), int'(m_stack.size() == 0));
      check("full",  int'(stack_full),  int'(m_stack.size() == SD));
      check("err",   int'(stack_err),   int'(m_err));
   endtask

   initial begin
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      check("reset_addr_20", int'(count_r), 32'h20);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, $urandom_range(1, 4), $urandom_range(0, 255));
      // Wrap and branch
      step(0, 1, 1, 8'hFE); step(0, 1, 0, 0); step(0, 1, 0, 0);
      step(0, 1, 1, 8'h10); step(0, 1, 2, 8'hFC); step(0, 1, 2, 8'h05);
      // Nesting
      step(0, 1, 1, 8'h03); step(0, 1, 3, 8'h40); step(0, 1, 3, 8'h80);
      step(0, 1, 4, 0);     step(0, 1, 4, 0);
      // Overflow then drain
      step(0, 1, 3, 8'h10); step(0, 1, 3, 8'h20); step(0, 1, 3, 8'h30);
      step(0, 1, 3, 8'h50); step(0, 1, 3, 8'h99);
      for (int i = 0; i < 4; i++) step(0, 1, 4, 0);
      // Underflow, then reset coinciding with a CALL
      step(1, 0, 0, 0);
      step(0, 1, 1, 8'h30); step(0, 1, 4, 0);
      step(0, 1, 3, 8'h40); step(1, 1, 3, 8'h60);
      step(0, 1, 4, 0);
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
              $urandom_range(0, 7), $urandom_range(0, 255));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
